// File: rtl/pfiform_seq.sv
// Join/pop sequencer for the byte reformatter: meters a job of cfg_total_bytes in
// through join beats and out through pop beats, with abort and no-progress watchdog.
//
// state | meaning
// IDLE  | waiting for cfg_start; counters and latched config cleared
// RUN   | accepting join beats from upstream, pops allowed
// DRAIN | all bytes joined, only pops remain
// DONE  | one-cycle job-complete pulse, then back to IDLE
module pfiform_seq #(
    parameter int CNT_W    = 16,
    parameter int WDOG_CYC = 1024
) (
    input  logic             i_core_clk,
    input  logic             i_rx_rstn,
    input  logic             cfg_start,
    input  logic             cfg_abort,
    input  logic [CNT_W-1:0] cfg_total_bytes,
    input  logic [4:0]       cfg_join_amt,
    input  logic [4:0]       cfg_pop_amt,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic             src_valid,
    output logic             src_ready,
    output logic             JoinEnable,
    input  logic             JoinPermit,
    output logic [4:0]       JoinAmout,
    output logic             PopPermit,
    input  logic             PopEnable,
    output logic [4:0]       PopAmout,
    input  logic             sink_ready,
    output logic             out_last,
    output logic             fifo_flush
);

    localparam int              WD_W     = (WDOG_CYC > 2) ? $clog2(WDOG_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WDOG_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_join_rem;
    logic [CNT_W-1:0] w_join_rem_nxt;
    logic [CNT_W-1:0] r_pop_rem;
    logic [CNT_W-1:0] w_pop_rem_nxt;
    logic [4:0]       r_join_amt;
    logic [4:0]       w_join_amt_nxt;
    logic [4:0]       r_pop_amt;
    logic [4:0]       w_pop_amt_nxt;
    logic [WD_W-1:0]  r_wdog;
    logic [WD_W-1:0]  w_wdog_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             r_flush;
    logic             w_flush_nxt;

    logic             w_active;
    logic             w_join_short;
    logic             w_pop_short;
    logic             w_pop_act;
    logic             w_progress;
    logic             w_cfg_bad;

    assign w_active     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_join_short = r_join_rem < CNT_W'(r_join_amt);
    assign w_pop_short  = r_pop_rem < CNT_W'(r_pop_amt);

    assign JoinAmout  = w_join_short ? r_join_rem[4:0] : r_join_amt;
    assign PopAmout   = w_pop_short ? r_pop_rem[4:0] : r_pop_amt;

    assign src_ready  = (r_state == ST_RUN) && JoinPermit && (r_join_rem != '0);
    assign JoinEnable = src_valid && src_ready;
    assign PopPermit  = w_active && (r_pop_rem != '0) && sink_ready;

    // Pops outside an active job are ignored, so they neither count nor feed the watchdog.
    assign w_pop_act  = PopEnable && w_active;
    assign out_last   = w_pop_act && (r_pop_rem != '0) && (r_pop_rem <= CNT_W'(PopAmout));
    assign w_progress = JoinEnable || w_pop_act;

    assign w_cfg_bad  = (cfg_total_bytes == '0) || (cfg_join_amt == '0) || (cfg_pop_amt == '0);

    assign busy       = w_active;
    assign done       = (r_state == ST_DONE) && !cfg_abort;
    assign err        = r_err;
    assign fifo_flush = r_flush;

    always_comb begin
        w_state_nxt    = r_state;
        w_join_rem_nxt = r_join_rem;
        w_pop_rem_nxt  = r_pop_rem;
        w_join_amt_nxt = r_join_amt;
        w_pop_amt_nxt  = r_pop_amt;
        w_wdog_nxt     = r_wdog;
        w_err_nxt      = 1'b0;
        w_flush_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_wdog_nxt = '0;
                if (cfg_start) begin
                    if (w_cfg_bad) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_join_rem_nxt = cfg_total_bytes;
                        w_pop_rem_nxt  = cfg_total_bytes;
                        w_join_amt_nxt = cfg_join_amt;
                        w_pop_amt_nxt  = cfg_pop_amt;
                        w_state_nxt    = ST_RUN;
                    end
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (JoinEnable) begin
                    w_join_rem_nxt = r_join_rem - CNT_W'(JoinAmout);
                end
                if (w_pop_act) begin
                    w_pop_rem_nxt = r_pop_rem - CNT_W'(PopAmout);
                end
                w_wdog_nxt = w_progress ? '0 : r_wdog + WD_W'(1);

                // Abort beats completion and timeout; final pop beats the RUN->DRAIN step.
                if (cfg_abort) begin
                    w_flush_nxt = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (out_last) begin
                    w_state_nxt = ST_DONE;
                end else if (!w_progress && (r_wdog == WD_LIMIT)) begin
                    w_err_nxt   = 1'b1;
                    w_flush_nxt = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if ((r_state == ST_RUN) && JoinEnable && (w_join_rem_nxt == '0)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DONE: begin
                w_flush_nxt = cfg_abort;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Leaving a job always returns the datapath-facing outputs to zero.
        if (w_state_nxt == ST_IDLE) begin
            w_join_rem_nxt = '0;
            w_pop_rem_nxt  = '0;
            w_join_amt_nxt = '0;
            w_pop_amt_nxt  = '0;
            w_wdog_nxt     = '0;
        end
    end

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            r_state    <= ST_IDLE;
            r_join_rem <= '0;
            r_pop_rem  <= '0;
            r_join_amt <= '0;
            r_pop_amt  <= '0;
            r_wdog     <= '0;
            r_err      <= 1'b0;
            r_flush    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_join_rem <= w_join_rem_nxt;
            r_pop_rem  <= w_pop_rem_nxt;
            r_join_amt <= w_join_amt_nxt;
            r_pop_amt  <= w_pop_amt_nxt;
            r_wdog     <= w_wdog_nxt;
            r_err      <= w_err_nxt;
            r_flush    <= w_flush_nxt;
        end
    end

endmodule

// File: tb/tb_pfiform_seq.sv
// Scoreboard bench for pfiform_seq: expected join/pop beats and status pulses are queued
// with the stimulus; a negedge monitor pops and compares whenever the DUT shows them.
module tb_pfiform_seq;

    logic        clk;
    logic        rst_n;
    logic        cfg_start;
    logic        cfg_abort;
    logic [15:0] cfg_total_bytes;
    logic [4:0]  cfg_join_amt;
    logic [4:0]  cfg_pop_amt;
    logic        busy;
    logic        done;
    logic        err;
    logic        src_valid;
    logic        src_ready;
    logic        JoinEnable;
    logic        JoinPermit;
    logic [4:0]  JoinAmout;
    logic        PopPermit;
    logic        PopEnable;
    logic [4:0]  PopAmout;
    logic        sink_ready;
    logic        out_last;
    logic        fifo_flush;

    pfiform_seq #(.CNT_W(16), .WDOG_CYC(1024)) dut (
        .i_core_clk      (clk),
        .i_rx_rstn       (rst_n),
        .cfg_start       (cfg_start),
        .cfg_abort       (cfg_abort),
        .cfg_total_bytes (cfg_total_bytes),
        .cfg_join_amt    (cfg_join_amt),
        .cfg_pop_amt     (cfg_pop_amt),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .src_valid       (src_valid),
        .src_ready       (src_ready),
        .JoinEnable      (JoinEnable),
        .JoinPermit      (JoinPermit),
        .JoinAmout       (JoinAmout),
        .PopPermit       (PopPermit),
        .PopEnable       (PopEnable),
        .PopAmout        (PopAmout),
        .sink_ready      (sink_ready),
        .out_last        (out_last),
        .fifo_flush      (fifo_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         total;
    int         bad;
    int         occ;
    int         cyc_cnt;
    int         busy_cnt;
    logic       m_valid;
    logic       m_pop;
    logic       m_jp;
    logic       m_jp_tog;
    logic       chk_sr;
    logic       pop_go;
    int         q_join[$];
    logic [5:0] q_pop[$];
    logic [2:0] q_evt[$];
    logic [5:0] mon_pe;
    logic [2:0] mon_obs;
    logic [2:0] mon_exp;
    int         mon_je;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic unexp(input string nm, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s actual=%0d required=none", nm, act);
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic start_job(input int tot, input int ja, input int pa);
        cfg_total_bytes = 16'(tot);
        cfg_join_amt    = 5'(ja);
        cfg_pop_amt     = 5'(pa);
        cfg_start       = 1'b1;
        tick();
        cfg_start       = 1'b0;
    endtask

    task automatic push_pop(input int amt, input logic last);
        q_pop.push_back({last, 5'(amt)});
    endtask

    task automatic wait_empty(input string nm, input int budget);
        int n;
        n = 0;
        while ((q_join.size() != 0 || q_pop.size() != 0 || q_evt.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            total++;
            bad++;
            $display("FAIL %s_timeout actual=%0d cycles required<%0d", nm, n, budget);
        end
        chk({nm, "_joins_left"}, q_join.size(), 0);
        chk({nm, "_pops_left"}, q_pop.size(), 0);
        chk({nm, "_evts_left"}, q_evt.size(), 0);
        q_join.delete();
        q_pop.delete();
        q_evt.delete();
    endtask

    // Reformatter model: pops only when enough joined bytes are buffered.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc_cnt++;
            src_valid  = m_valid;
            JoinPermit = m_jp_tog ? (((cyc_cnt / 2) % 2) == 0) : m_jp;
            sink_ready = 1'b1;
            #1;
            pop_go    = m_pop && PopPermit && (PopAmout != 5'd0) && (occ >= int'(PopAmout));
            PopEnable = pop_go;
            if (JoinEnable) occ = occ + int'(JoinAmout);
            if (pop_go) occ = occ - int'(PopAmout);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_cnt++;
            if (chk_sr) chk("src_ready_without_permit", 32'(src_ready && !JoinPermit), 0);
            if (JoinEnable) begin
                if (q_join.size() == 0) unexp("join_beat", 32'(JoinAmout));
                else begin
                    mon_je = q_join.pop_front();
                    chk("join_amt", 32'(JoinAmout), mon_je);
                end
            end
            if (PopEnable) begin
                if (q_pop.size() == 0) unexp("pop_beat", 32'(PopAmout));
                else begin
                    mon_pe = q_pop.pop_front();
                    chk("pop_amt", 32'(PopAmout), 32'(mon_pe[4:0]));
                    chk("pop_last", 32'(out_last), 32'(mon_pe[5]));
                end
            end else begin
                chk("out_last_without_pop", 32'(out_last), 0);
            end
            mon_obs = {done, err, fifo_flush};
            if (mon_obs != 3'b000) begin
                if (q_evt.size() == 0) unexp("status_done_err_flush", 32'(mon_obs));
                else begin
                    mon_exp = q_evt.pop_front();
                    chk("status_done_err_flush", 32'(mon_obs), 32'(mon_exp));
                end
            end
        end
    end

    initial begin
        total = 0; bad = 0; occ = 0; cyc_cnt = 0; busy_cnt = 0;
        rst_n = 1'b0;
        cfg_start = 1'b0; cfg_abort = 1'b0;
        cfg_total_bytes = '0; cfg_join_amt = '0; cfg_pop_amt = '0;
        src_valid = 1'b0; JoinPermit = 1'b0; PopEnable = 1'b0; sink_ready = 1'b0;
        m_valid = 1'b0; m_pop = 1'b0; m_jp = 1'b1; m_jp_tog = 1'b0; chk_sr = 1'b0;
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_flush", 32'(fifo_flush), 0);
        chk("rst_join_amt", 32'(JoinAmout), 0);
        chk("rst_pop_amt", 32'(PopAmout), 0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();

        // 100 bytes, join 10, pop 19: ten joins of 10, five pops of 19, last pop of 5.
        occ = 0; m_valid = 1'b1; m_pop = 1'b1;
        for (int i = 0; i < 10; i++) q_join.push_back(10);
        for (int i = 0; i < 5; i++) push_pop(19, 1'b0);
        push_pop(5, 1'b1);
        q_evt.push_back(3'b100);
        start_job(100, 10, 19);
        wait_empty("job100", 300);
        m_valid = 1'b0;
        tick();

        // 46 bytes with JoinPermit toggling; a mid-job cfg_start must be ignored.
        occ = 0; m_valid = 1'b1; m_pop = 1'b1; m_jp_tog = 1'b1; chk_sr = 1'b1;
        q_join.push_back(23);
        q_join.push_back(23);
        push_pop(15, 1'b0);
        push_pop(15, 1'b0);
        push_pop(15, 1'b0);
        push_pop(1, 1'b1);
        q_evt.push_back(3'b100);
        start_job(46, 23, 15);
        repeat (3) tick();
        start_job(5, 1, 1);
        wait_empty("job46", 300);
        chk_sr = 1'b0; m_jp_tog = 1'b0; m_valid = 1'b0;
        tick();

        // Illegal configurations: err pulse only, no beats, never busy.
        m_valid = 1'b1; m_pop = 1'b0;
        q_evt.push_back(3'b010);
        start_job(0, 10, 10);
        wait_empty("bad_total", 20);
        chk("bad_total_busy", 32'(busy), 0);
        q_evt.push_back(3'b010);
        start_job(20, 0, 10);
        wait_empty("bad_join", 20);
        chk("bad_join_busy", 32'(busy), 0);
        q_evt.push_back(3'b010);
        start_job(20, 10, 0);
        wait_empty("bad_pop", 20);
        chk("bad_pop_busy", 32'(busy), 0);
        m_valid = 1'b0;
        tick();

        // Watchdog: no progress for 1024 busy cycles, then err with flush.
        occ = 0; busy_cnt = 0;
        q_evt.push_back(3'b011);
        start_job(50, 10, 10);
        wait_empty("wdog", 1200);
        chk("wdog_busy_cycles", 32'(busy_cnt), 1024);
        chk("wdog_idle_busy", 32'(busy), 0);
        tick();

        // Abort in DRAIN with 30 bytes still to pop, then a normal job.
        occ = 0; m_valid = 1'b1; m_pop = 1'b0;
        q_join.push_back(15);
        q_join.push_back(15);
        start_job(30, 15, 10);
        wait_empty("pre_abort", 50);
        m_valid = 1'b0;
        tick();
        chk("drain_busy", 32'(busy), 1);
        q_evt.push_back(3'b001);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        wait_empty("abort", 10);
        occ = 0; m_valid = 1'b1; m_pop = 1'b1;
        q_join.push_back(20);
        push_pop(20, 1'b1);
        q_evt.push_back(3'b100);
        start_job(20, 20, 20);
        wait_empty("post_abort", 50);
        m_valid = 1'b0;
        tick();

        // Reset while a join is in flight: outputs drop before the next edge.
        occ = 0; m_pop = 1'b0;
        start_job(100, 10, 19);
        q_join.push_back(10);
        m_valid = 1'b1;
        tick();
        tick();
        chk("pre_rst_join", 32'(JoinEnable), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_src_ready", 32'(src_ready), 0);
        chk("mid_rst_join_en", 32'(JoinEnable), 0);
        chk("mid_rst_join_amt", 32'(JoinAmout), 0);
        chk("mid_rst_pop_amt", 32'(PopAmout), 0);
        chk("mid_rst_pop_permit", 32'(PopPermit), 0);
        m_valid = 1'b0;
        repeat (3) tick();
        chk("rst_joins_seen", q_join.size(), 0);
        rst_n = 1'b1;
        repeat (5) tick();
        occ = 0; m_valid = 1'b1; m_pop = 1'b1;
        q_join.push_back(10);
        push_pop(10, 1'b1);
        q_evt.push_back(3'b100);
        start_job(10, 10, 10);
        wait_empty("post_rst", 50);
        m_valid = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
